// File: rtl/ifetch_unit.sv
// Multicycle rv32i instruction fetch: PC register, imem request/ack handshake, decode hand-off.
// Define IFETCH_MISALIGN_CHECK_EN to trap misaligned next-PC targets into a sticky ERR state.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [24:0] inm,
    output logic [1:0]  src,
    input  logic [31:0] inmExt,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        take_branch,
    input  logic        pc_load,
    input  logic [31:0] pc_load_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, VALID, ERR} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_r, instr_r, pc_target;
    logic [1:0]  src_r;
    logic        req_r, vld_r;
    logic        latch, advance, trap, target_bad;

    function automatic logic [1:0] decode_src(input logic [6:0] opcode);
        case (opcode)
            7'b0100011: decode_src = 2'b01;
            7'b1100011: decode_src = 2'b10;
            7'b1101111: decode_src = 2'b11;
            default:    decode_src = 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        align_pc = addr & ~32'd3;
    endfunction

    // JALR target outranks a taken branch; arithmetic wraps modulo 2^32.
    always_comb begin
        pc_target = pc_r + 32'd4;
        if (pc_load)
            pc_target = pc_load_addr;
        else if (take_branch)
            pc_target = pc_r + inmExt;
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign target_bad = (pc_target[1:0] != 2'b00);
`else
    assign target_bad = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        advance   = 1'b0;
        trap      = 1'b0;
        case (state)
            REQ: begin
                if (req_r && imem_ack) begin
                    latch     = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    if (target_bad) begin
                        trap      = 1'b1;
                        state_nxt = ERR;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= REQ;
        else
            state <= state_nxt;
    end

    // The request rises one cycle after REQ entry and drops on the accepted ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_r   <= 1'b0;
            vld_r   <= 1'b0;
            pc_r    <= RESET_PC;
            instr_r <= NOP;
            src_r   <= 2'b00;
        end else begin
            req_r <= (state == REQ) && !latch;
            if (latch)
                vld_r <= 1'b1;
            else if (advance || trap)
                vld_r <= 1'b0;
            if (latch) begin
                instr_r <= imem_rdata;
                src_r   <= decode_src(imem_rdata[6:0]);
            end
            if (advance)
                pc_r <= align_pc(pc_target);
        end
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic mis_r;

    always_ff @(posedge clk) begin
        if (reset)
            mis_r <= 1'b0;
        else if (trap)
            mis_r <= 1'b1;
    end

    assign misaligned = mis_r;
`else
    assign misaligned = 1'b0;
`endif

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_r + 32'd4;
    assign instr       = instr_r;
    assign inm         = instr_r[31:7];
    assign src         = src_r;
    assign instr_valid = vld_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized fetch/branch traffic
// compared against a transaction-level PC/instruction model.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [24:0] inm;
    logic [1:0]  src;
    logic [31:0] inmExt;
    logic        instr_valid;
    logic        instr_ready;
    logic        take_branch;
    logic        pc_load;
    logic [31:0] pc_load_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mpc;
    logic [31:0] last_word;
    bit          trapped;

    ifetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .inm(inm), .src(src), .inmExt(inmExt),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .take_branch(take_branch), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
        .pc(pc), .pc_plus4(pc_plus4), .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] ref_src(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h23)      return 2'b01;
        else if (op == 7'h63) return 2'b10;
        else if (op == 7'h6F) return 2'b11;
        else                  return 2'b00;
    endfunction

    // Called at the negedge of a REQ entry cycle (request not yet raised).
    task automatic do_fetch(input logic [31:0] word, input int dly, input bit stray);
        logic [31:0] exp_inm;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL req_entry got %b want 0", imem_req); end
        if (stray) begin imem_ack = 1'b1; imem_rdata = ~word; end
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL req_rise got %b want 1", imem_req); end
        checks++; if (imem_addr !== mpc) begin errors++; $display("FAIL imem_addr got %h want %h", imem_addr, mpc); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stray_ack_valid got %b want 0", instr_valid); end
        repeat (dly) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== mpc) begin
                errors++; $display("FAIL req_hold req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, mpc);
            end
        end
        imem_ack = 1'b1; imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        last_word = word;
        exp_inm = word >> 7;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL valid_set got %b want 1", instr_valid); end
        checks++; if (instr !== word) begin errors++; $display("FAIL instr got %h want %h", instr, word); end
        checks++; if (pc !== mpc) begin errors++; $display("FAIL pc got %h want %h", pc, mpc); end
        checks++; if (src !== ref_src(word)) begin errors++; $display("FAIL src got %b want %b", src, ref_src(word)); end
        checks++; if (inm !== exp_inm[24:0]) begin errors++; $display("FAIL inm got %h want %h", inm, exp_inm[24:0]); end
        checks++; if (pc_plus4 !== mpc + 32'd4) begin errors++; $display("FAIL pc_plus4 got %h want %h", pc_plus4, mpc + 32'd4); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL req_drop got %b want 0", imem_req); end
    endtask

    // Holds VALID for some cycles with noise on ignored inputs, then consumes.
    task automatic do_consume(input int hold, input bit br, input bit ld,
                              input logic [31:0] ext, input logic [31:0] addr);
        logic [31:0] tgt;
        repeat (hold) begin
            imem_ack = 1'($urandom_range(0, 1));
            take_branch = 1'($urandom_range(0, 1));
            pc_load = 1'($urandom_range(0, 1));
            inmExt = $urandom; pc_load_addr = $urandom; imem_rdata = $urandom;
            @(negedge clk);
            imem_ack = 1'b0;
            checks++;
            if (instr_valid !== 1'b1 || instr !== last_word || pc !== mpc) begin
                errors++; $display("FAIL valid_hold valid=%b instr=%h pc=%h want 1 %h %h", instr_valid, instr, pc, last_word, mpc);
            end
        end
        instr_ready = 1'b1; take_branch = br; pc_load = ld; inmExt = ext; pc_load_addr = addr;
        @(negedge clk);
        instr_ready = 1'b0; take_branch = 1'b0; pc_load = 1'b0;
        tgt = ld ? addr : (br ? mpc + ext : mpc + 32'd4);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL valid_clear got %b want 0", instr_valid); end
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (tgt % 4 != 0) begin
            trapped = 1'b1;
            checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL misaligned_set got %b want 1", misaligned); end
        end else begin
            mpc = tgt;
            checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL misaligned_clr got %b want 0", misaligned); end
        end
`else
        mpc = tgt - (tgt % 4);
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL misaligned_tied got %b want 0", misaligned); end
`endif
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", pc, RESET_PC); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
        checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr got %h want 00000013", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b want 0", misaligned); end
        checks++; if (src !== 2'b00) begin errors++; $display("FAIL reset_src got %b want 00", src); end
        reset = 1'b0;
        mpc = RESET_PC;
        trapped = 1'b0;
    endtask

    task automatic test_first_fetch;
        do_fetch(32'h0050_0093, 2, 1'b0);
        checks++; if (inm !== 25'h00A001) begin errors++; $display("FAIL first_inm got %h want 00a001", inm); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL first_pc got %h want 0", pc); end
    endtask

    task automatic test_sequential_and_branch;
        do_consume(1, 1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(32'h0000_0013, 0, 1'b1);
        do_consume(0, 1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(32'hFE00_0EE3, 1, 1'b0);
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL branch_src_pc got %h want 8", pc); end
        checks++; if (src !== 2'b10) begin errors++; $display("FAIL branch_src got %b want 10", src); end
        do_consume(2, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
        checks++; if (mpc !== 32'h4) begin errors++; $display("FAIL branch_target got %h want 4", mpc); end
        do_fetch(32'h0000_0067, 0, 1'b0);
        do_consume(0, 1'b1, 1'b1, 32'h40, 32'h100);
        do_fetch(32'h0000_006F, 3, 1'b0);
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL jalr_priority got %h want 100", imem_addr); end
    endtask

    task automatic test_wrap;
        do_consume(0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
        do_fetch($urandom, 1, 1'b0);
        do_consume(0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (mpc !== 32'h0) begin errors++; $display("FAIL wrap_model got %h want 0", mpc); end
        do_fetch(32'h0000_0023, 0, 1'b0);
    endtask

    task automatic test_random;
        logic [6:0]  ops [8] = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h37};
        logic [31:0] w, ext, addr;
        for (int i = 0; i < 40; i++) begin
            ext = $urandom; ext[1:0] = 2'b00;
            addr = $urandom; addr[1:0] = 2'b00;
            do_consume($urandom_range(0, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ext, addr);
            w = $urandom; w[6:0] = ops[$urandom_range(0, 7)];
            do_fetch(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid;
        do_consume(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_req_pre got %b want 1", imem_req); end
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0; reset = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h13) begin errors++; $display("FAIL mid_instr got %h want 00000013", instr); end
        checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL mid_pc got %h want %h", pc, RESET_PC); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b want 0", imem_req); end
        mpc = RESET_PC;
        do_fetch(32'h0010_0113, 1, 1'b0);
    endtask

    task automatic test_misalign;
        do_consume(0, 1'b0, 1'b1, 32'h0, 32'h102);
`ifdef IFETCH_MISALIGN_CHECK_EN
        checks++; if (!trapped) begin errors++; $display("FAIL trap_model got 0 want 1"); end
        repeat (4) begin
            imem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            imem_ack = 1'b0;
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b1) begin
                errors++; $display("FAIL err_hold req=%b valid=%b mis=%b want 0 0 1", imem_req, instr_valid, misaligned);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL err_reset got %b want 0", misaligned); end
        mpc = RESET_PC;
        do_fetch(32'h0000_0013, 0, 1'b0);
`else
        checks++; if (mpc !== 32'h100) begin errors++; $display("FAIL align_model got %h want 100", mpc); end
        do_fetch(32'h0000_0013, 0, 1'b0);
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL align_pc got %h want 100", pc); end
`endif
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; inmExt = 32'h0;
        instr_ready = 1'b0; take_branch = 1'b0; pc_load = 1'b0; pc_load_addr = 32'h0;
        mpc = RESET_PC; last_word = 32'h13; trapped = 1'b0;
        test_reset;
        test_first_fetch;
        test_sequential_and_branch;
        test_wrap;
        test_random;
        test_reset_mid;
        test_misalign;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
